result_collector: RTL and testbench

- Output-side counterpart of the matmul control unit. The control unit reads the A/B buffers and pulses `valid` once per finished dot product.
- This block takes each result, writes it row-major into the C buffer, then reads C back out to the host over a valid/ready stream.
- It sits between the accumulator register and the host interface, and signals completion of the whole product.

---
 rtl/mm_pkg.sv | 19 +
 rtl/rc_index_counter.sv | 84 ++++++++
 rtl/result_collector.sv | 214 +++++++++++++++++++++
 tb/tb_result_collector.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matmul output-side blocks.
//   - default widths for the matrix index, C-buffer address and result data
//   - state encoding of the result collector FSM
package mm_pkg;

    localparam int N_DEF = 8;
    localparam int M_DEF = 8;
    localparam int W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_RD      = 3'd2,
        ST_RWAIT   = 3'd3,
        ST_OUT     = 3'd4,
        ST_FIN     = 3'd5
    } rc_state_e;

endpackage

// File: rtl/rc_index_counter.sv
// Row/column/linear-address tracker for the C matrix, walked row-major.
// Shared by the collect phase (one step per C write) and the drain phase
// (one step per accepted host beat).
//   clk, rst     : clock, synchronous active-low reset
//   clear        : zero row/col/addr (has priority over advance)
//   advance      : step to the next element
//   dim2         : number of columns of C
//   total        : number of elements of C
//   row, col     : current element indices
//   addr         : current linear address (row*dim2 + col)
//   last         : current element is the final one (addr == total-1)
module rc_index_counter
    import mm_pkg::*;
#(
    parameter int n = N_DEF,
    parameter int m = M_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           advance,
    input  logic [n-1:0]   dim2,
    input  logic [2*n-1:0] total,
    output logic [n-1:0]   row,
    output logic [n-1:0]   col,
    output logic [m-1:0]   addr,
    output logic           last
);

    localparam int XW = 2*n + m;

    logic [n-1:0]  row_q, row_d;
    logic [n-1:0]  col_q, col_d;
    logic [m-1:0]  addr_q, addr_d;
    logic [XW-1:0] addr_x, total_x;

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (clear) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (advance) begin
            addr_d = addr_q + m'(1);
            if (col_q == dim2 - n'(1)) begin
                col_d = '0;
                row_d = row_q + n'(1);
            end else begin
                col_d = col_q + n'(1);
            end
        end
    end

    // Compare in a common width so neither addr nor total is truncated.
    always_comb begin
        addr_x = XW'(addr_q);
        total_x = XW'(total);
        last = (total_x != '0) && (addr_x == total_x - XW'(1));
    end

    assign row  = row_q;
    assign col  = col_q;
    assign addr = addr_q;

    a_index_invariant : assert property (
        @(posedge clk) disable iff (!rst)
        (32'(row_q) * 32'(dim2) + 32'(col_q)) == 32'(addr_q)
    );

endmodule

// File: rtl/result_collector.sv
// Result collector: stores each finished dot product row-major into the
// C buffer, then streams C back to the host over valid/ready and pulses
// done when the whole product has been delivered.
//   clk, rst                 : clock, synchronous active-low reset
//   start, dim0, dim2        : launch a collection of a dim0 x dim2 result
//   res_valid, res_data      : finished C element from the control unit
//   cwr, crd, cadr, cdata    : C-buffer write/read strobes, address, write data
//   crdata                   : C-buffer read data, one cycle after crd
//   out_valid/ready/data     : host stream, with out_row/out_col indices
//   busy, done, err          : status (err is sticky until an accepted start)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start
// COLLECT  | writing incoming results to C
// RD       | issuing a C-buffer read (waits out a pending write first)
// RWAIT    | read data arriving, captured into the output register
// OUT      | presenting one element to the host
// FIN      | one-cycle done pulse
module result_collector
    import mm_pkg::*;
#(
    parameter int n = N_DEF,
    parameter int m = M_DEF,
    parameter int w = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dim0,
    input  logic [n-1:0] dim2,
    input  logic         res_valid,
    input  logic [w-1:0] res_data,
    output logic         cwr,
    output logic         crd,
    output logic [m-1:0] cadr,
    output logic [w-1:0] cdata,
    input  logic [w-1:0] crdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [w-1:0] out_data,
    output logic [n-1:0] out_row,
    output logic [n-1:0] out_col,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int TW = 2*n;

    rc_state_e     state_q, state_d;
    logic [n-1:0]  dim2_q, dim2_d;
    logic [TW-1:0] total_q, total_d;
    logic          err_q, err_d;
    logic          cwr_q, cwr_d;
    logic [m-1:0]  cadr_q, cadr_d;
    logic [w-1:0]  cdata_q, cdata_d;
    logic          out_valid_q, out_valid_d;
    logic [w-1:0]  out_data_q, out_data_d;
    logic [n-1:0]  out_row_q, out_row_d;
    logic [n-1:0]  out_col_q, out_col_d;

    logic          cnt_clear, cnt_adv;
    logic [n-1:0]  idx_row, idx_col;
    logic [m-1:0]  idx_addr;
    logic          idx_last;
    logic [TW-1:0] prod;
    logic          too_big;

    rc_index_counter #(.n(n), .m(m)) u_idx (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .dim2    (dim2_q),
        .total   (total_q),
        .row     (idx_row),
        .col     (idx_col),
        .addr    (idx_addr),
        .last    (idx_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            dim2_q      <= '0;
            total_q     <= '0;
            err_q       <= 1'b0;
            cwr_q       <= 1'b0;
            cadr_q      <= '0;
            cdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            dim2_q      <= dim2_d;
            total_q     <= total_d;
            err_q       <= err_d;
            cwr_q       <= cwr_d;
            cadr_q      <= cadr_d;
            cdata_q     <= cdata_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dim2_d      = dim2_q;
        total_d     = total_q;
        err_d       = err_q;
        cwr_d       = 1'b0;
        cadr_d      = cadr_q;
        cdata_d     = cdata_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        cnt_clear   = 1'b0;
        cnt_adv     = 1'b0;

        prod    = TW'(dim0) * TW'(dim2);
        too_big = 64'(prod) > (64'd1 << m);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dim2_d    = dim2;
                    total_d   = prod;
                    err_d     = 1'b0;
                    cnt_clear = 1'b1;
                    if (prod == '0) begin
                        state_d = ST_FIN;
                    end else if (too_big) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (res_valid) begin
                    cwr_d   = 1'b1;
                    cadr_d  = idx_addr;
                    cdata_d = res_data;
                    if (idx_last) begin
                        cnt_clear = 1'b1;
                        state_d   = ST_RD;
                    end else begin
                        cnt_adv = 1'b1;
                    end
                end
            end
            ST_RD: begin
                // The final write is still on the bus in the first RD cycle;
                // hold off the read so cwr and crd never overlap.
                if (!cwr_q) begin
                    cadr_d  = idx_addr;
                    state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                out_data_d  = crdata;
                out_valid_d = 1'b1;
                out_row_d   = idx_row;
                out_col_d   = idx_col;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_last) begin
                        cnt_clear = 1'b1;
                        state_d   = ST_FIN;
                    end else begin
                        cnt_adv = 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Results arriving outside COLLECT are dropped and flagged.
        if (res_valid && (state_q != ST_COLLECT)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);
        crd       = (state_q == ST_RD) && !cwr_q;
        cadr      = crd ? idx_addr : cadr_q;
        cwr       = cwr_q;
        cdata     = cdata_q;
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_row   = out_row_q;
        out_col   = out_col_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

    localparam int N = 8;
    localparam int M = 8;
    localparam int W = 16;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int row;
        int col;
        int data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dim0, dim2;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         cwr, crd;
    logic [M-1:0] cadr;
    logic [W-1:0] cdata;
    logic [W-1:0] crdata = '0;
    logic         out_valid, out_ready;
    logic [W-1:0] out_data;
    logic [N-1:0] out_row, out_col;
    logic         busy, done, err;

    logic [W-1:0] cmem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    wr_t   wq[$];
    beat_t bq[$];
    wr_t   w_e;
    beat_t b_e;

    int wr_seen  = 0;
    int beats    = 0;
    int done_cnt = 0;
    int run      = 0;
    int run_max  = 0;
    int ready_mode = 0;
    int ready_ph   = 0;

    logic         prev_ov = 1'b0, prev_or = 1'b0;
    logic [W-1:0] prev_data;
    logic [N-1:0] prev_row, prev_col;

    result_collector #(.n(N), .m(M), .w(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dim0      (dim0),
        .dim2      (dim2),
        .res_valid (res_valid),
        .res_data  (res_data),
        .cwr       (cwr),
        .crd       (crd),
        .cadr      (cadr),
        .cdata     (cdata),
        .crdata    (crdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // C-buffer model: synchronous write, read data one cycle after crd.
    always @(posedge clk) begin
        if (cwr) cmem[cadr] <= cdata;
        if (crd) crdata <= cmem[cadr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Host ready: mode 0 always ready, mode 1 repeats 1,0,0.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else begin
                out_ready = (ready_ph % 3 == 0);
                ready_ph++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (cwr || crd) chk("cwr_crd_excl", 32'(cwr && crd), 0);
            if (cwr) begin
                wr_seen++;
                run++;
                if (wq.size() == 0) begin
                    chk("cwr_spurious", 32'(cwr), 0);
                end else begin
                    w_e = wq.pop_front();
                    chk("cadr", 32'(cadr), w_e.addr);
                    chk("cdata", 32'(cdata), w_e.data);
                end
            end else begin
                run = 0;
            end
            if (run > run_max) run_max = run;
            if (prev_ov && !prev_or) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_row", 32'(out_row), 32'(prev_row));
                chk("hold_col", 32'(out_col), 32'(prev_col));
            end
            if (out_valid && out_ready) begin
                beats++;
                if (bq.size() == 0) begin
                    chk("beat_spurious", 32'(out_valid), 0);
                end else begin
                    b_e = bq.pop_front();
                    chk("out_row", 32'(out_row), b_e.row);
                    chk("out_col", 32'(out_col), b_e.col);
                    chk("out_data", 32'(out_data), b_e.data);
                end
            end
            if (done) done_cnt++;
            prev_ov   = out_valid;
            prev_or   = out_ready;
            prev_data = out_data;
            prev_row  = out_row;
            prev_col  = out_col;
        end else begin
            prev_ov = 1'b0;
            run     = 0;
        end
    end

    task automatic start_op(input int d0, input int d2);
        @(posedge clk);
        #1;
        dim0  = N'(d0);
        dim2  = N'(d2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drive_res(input int idx, input int d2, input int data);
        wr_t   we;
        beat_t be;
        res_valid = 1'b1;
        res_data  = W'(data);
        we.addr = idx;
        we.data = data;
        wq.push_back(we);
        be.row  = idx / d2;
        be.col  = idx % d2;
        be.data = data;
        bq.push_back(be);
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc >= budget) begin
                chk("done_timeout", 32'(done), 1);
                break;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_cwr"}, 32'(cwr), 0);
        chk({tag, "_crd"}, 32'(crd), 0);
        chk({tag, "_cadr"}, 32'(cadr), 0);
        chk({tag, "_cdata"}, 32'(cdata), 0);
        chk({tag, "_ovalid"}, 32'(out_valid), 0);
        chk({tag, "_odata"}, 32'(out_data), 0);
        chk({tag, "_orow"}, 32'(out_row), 0);
        chk({tag, "_ocol"}, 32'(out_col), 0);
    endtask

    task automatic run_op(input int d0, input int d2, input int base, input bit b2b);
        int tot;
        int cyc;
        int done0;
        tot      = d0 * d2;
        wr_seen  = 0;
        beats    = 0;
        run_max  = 0;
        done0    = done_cnt;
        start_op(d0, d2);
        if (tot == 0 || tot > 256) begin
            wait_done(10, cyc);
            chk("fin_latency", 32'(cyc), 1);
            chk("fin_err", 32'(err), (tot > 256) ? 1 : 0);
        end else begin
            @(negedge clk);
            chk("err_clr_on_start", 32'(err), 0);
            chk("busy_collect", 32'(busy), 1);
            if (b2b) begin
                for (int i = 0; i < tot; i++) begin
                    @(posedge clk);
                    #1;
                    drive_res(i, d2, base + i);
                end
                @(posedge clk);
                #1;
                res_valid = 1'b0;
            end else begin
                for (int i = 0; i < tot; i++) begin
                    @(posedge clk);
                    #1;
                    drive_res(i, d2, base + i);
                    @(posedge clk);
                    #1;
                    res_valid = 1'b0;
                    repeat (2) @(posedge clk);
                end
            end
            wait_done(tot * 12 + 50, cyc);
            chk("err_at_done", 32'(err), 0);
        end
        repeat (2) @(negedge clk);
        chk("done_pulses", 32'(done_cnt - done0), 1);
        chk("busy_after", 32'(busy), 0);
        chk("writes", 32'(wr_seen), (tot > 256) ? 0 : tot);
        chk("beats", 32'(beats), (tot > 256) ? 0 : tot);
        chk("wq_empty", 32'(wq.size()), 0);
        chk("bq_empty", 32'(bq.size()), 0);
        if (b2b && tot > 0 && tot <= 256) chk("b2b_run", 32'(run_max), tot);
    endtask

    initial begin
        int cyc;
        rst       = 1'b0;
        start     = 1'b0;
        dim0      = '0;
        dim2      = '0;
        res_valid = 1'b0;
        res_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_idle("reset");

        // 1: spaced results, always-ready drain
        run_op(2, 3, 10, 1'b0);

        // 2: back-to-back results
        run_op(2, 3, 20, 1'b1);

        // 3: drain with ready pattern 1,0,0
        ready_mode = 1;
        ready_ph   = 0;
        run_op(2, 3, 30, 1'b1);
        ready_mode = 0;

        // 4: empty product and oversized product
        run_op(0, 5, 0, 1'b0);
        run_op(20, 20, 0, 1'b0);

        // 5: result in IDLE is dropped and flags err; next start clears it
        @(posedge clk);
        #1;
        res_valid = 1'b1;
        res_data  = 16'd55;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        @(negedge clk);
        chk("err_idle_drop", 32'(err), 1);
        chk("busy_idle_drop", 32'(busy), 0);
        run_op(1, 1, 99, 1'b0);

        // 6: reset in the middle of collection, then a fresh 1x1 product
        wr_seen = 0;
        start_op(2, 3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            drive_res(i, 3, 10 + i);
            @(posedge clk);
            #1;
            res_valid = 1'b0;
            repeat (2) @(posedge clk);
        end
        @(negedge clk);
        chk("mid_writes", 32'(wr_seen), 3);
        chk("mid_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        wq.delete();
        bq.delete();
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        run_op(1, 1, 7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
